// File: rtl/beep_mixer.sv
// beep_mixer: drives the single speaker pin from one BGM square wave and
// SFX_N one-shot effect square waves.
//
// An active effect ducks the BGM, and effects have a fixed priority: index 0
// is the highest. A source change is deferred until the output is low, so the
// speaker never sees a clipped pulse. Mute and a 4-level volume are applied
// by PWM gating of the selected source.
//
// Optional feature: define BEEP_MIXER_FADE_EN to fade the volume in on every
// entry to BGM. The volume starts silent and rises one level every FADE_STEP
// cycles until it reaches vol. When the macro is not defined, the effective
// volume follows vol at once and no fade counter is built.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   gamemode    game state; selects a BGM_MASK bit
//   bgm_beep    BGM square wave
//   sfx_beep    effect square waves, one per source
//   sfx_req     one-cycle start pulses, one per source
//   mute        1 -> speaker silent; arbitration is unaffected
//   vol         volume 0..3
//   beep_out    registered speaker drive
//   sfx_busy    1 while in SFX or while switching towards an effect
//   active_src  0 = none, 1 = BGM, 2+i = effect i
module beep_mixer #(
  parameter int         SFX_N      = 2,
  parameter int         SFX_HOLD   = 25_000_000,
  parameter int         SW_TIMEOUT = 1_000_000,
  parameter logic [3:0] BGM_MASK   = 4'b0001
`ifdef BEEP_MIXER_FADE_EN
  , parameter int       FADE_STEP  = 6_250_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       gamemode,
  input  logic             bgm_beep,
  input  logic [SFX_N-1:0] sfx_beep,
  input  logic [SFX_N-1:0] sfx_req,
  input  logic             mute,
  input  logic [1:0]       vol,
  output logic             beep_out,
  output logic             sfx_busy,
  output logic [2:0]       active_src
);

  localparam int HOLD_W = $clog2(SFX_HOLD + 1);
  localparam int TO_W   = $clog2(SW_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BGM,
    ST_SWITCH,
    ST_SFX
  } state_t;

  state_t            state;
  logic [1:0]        sel;
  logic              tgt_none;
  logic [1:0]        tgt_idx;
  logic [HOLD_W-1:0] hold;
  logic [TO_W-1:0]   timeout;
  logic [3:0]        pwm_cnt;
  // Unmuted output level. The low-level switch condition is taken from this
  // register rather than from beep_out, so that mute never changes when a
  // state change happens.
  logic              raw_level;

  logic       req_any;
  logic [1:0] req_idx;
  logic       bgm_ok;
  logic       src;
  logic       retarget;
  logic       next_none;
  logic [1:0] next_idx;
  logic [2:0] vol_level;
  logic [4:0] duty;
  logic       gate;

  assign req_any = |sfx_req;
  assign bgm_ok  = BGM_MASK[gamemode];

  // Lowest set request index wins; the other simultaneous requests are dropped.
  always_comb begin
    req_idx = '0;
    for (int i = SFX_N - 1; i >= 0; i--) begin
      if (sfx_req[i]) req_idx = 2'(i);
    end
  end

  // The registered active_src names the source that currently drives the
  // output. During SWITCH it still names the previous source.
  always_comb begin
    src = 1'b0;
    if (active_src == 3'd1) src = bgm_beep;
    for (int i = 0; i < SFX_N; i++) begin
      if (active_src == 3'(i + 2)) src = sfx_beep[i];
    end
  end

  // A request that arrives during SWITCH re-targets the switch when its index
  // is lower than the pending target. A pending "none" target counts as the
  // lowest priority.
  assign retarget  = req_any && (tgt_none || (req_idx < tgt_idx));
  assign next_none = retarget ? 1'b0 : tgt_none;
  assign next_idx  = retarget ? req_idx : tgt_idx;

`ifdef BEEP_MIXER_FADE_EN
  localparam int FADE_W = $clog2(FADE_STEP + 1);

  logic [2:0]        fade_level;
  logic [FADE_W-1:0] fade_cnt;
  logic [2:0]        vol_cap;
  logic              enter_bgm;

  assign vol_cap   = 3'(vol) + 3'd1;
  assign enter_bgm = (state == ST_IDLE) && !req_any && bgm_ok;

  // Fade level 0 is silent. Level k plays at volume k-1. The level climbs
  // only while it is below vol+1, so a raised vol resumes the ramp instead
  // of jumping to the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      fade_level <= '0;
      fade_cnt   <= '0;
    end else if (enter_bgm) begin
      fade_level <= '0;
      fade_cnt   <= '0;
    end else if (fade_level < vol_cap) begin
      if (fade_cnt == FADE_W'(FADE_STEP - 1)) begin
        fade_cnt   <= '0;
        fade_level <= fade_level + 3'd1;
      end else begin
        fade_cnt <= fade_cnt + 1'b1;
      end
    end
  end

  // The fade applies only while BGM is the driving source.
  always_comb begin
    vol_level = vol_cap;
    if (active_src == 3'd1 && fade_level < vol_cap) vol_level = fade_level;
  end
`else
  always_comb begin
    vol_level = 3'(vol) + 3'd1;
  end
`endif

  // Map the volume level to a PWM duty out of 16. Level 0 exists only while
  // a fade is in progress.
  always_comb begin
    case (vol_level)
      3'd0:    duty = 5'd0;
      3'd1:    duty = 5'd1;
      3'd2:    duty = 5'd4;
      3'd3:    duty = 5'd8;
      default: duty = 5'd16;
    endcase
  end

  assign gate = {1'b0, pwm_cnt} < duty;

  // Source arbitration FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      tgt_none   <= 1'b1;
      tgt_idx    <= '0;
      hold       <= '0;
      timeout    <= '0;
      pwm_cnt    <= '0;
      raw_level  <= 1'b0;
      beep_out   <= 1'b0;
      sfx_busy   <= 1'b0;
      active_src <= 3'd0;
    end else begin
      pwm_cnt   <= pwm_cnt + 4'd1;
      raw_level <= src & gate;
      beep_out  <= !mute & src & gate;

      case (state)
        ST_IDLE: begin
          if (req_any) begin
            state    <= ST_SWITCH;
            tgt_none <= 1'b0;
            tgt_idx  <= req_idx;
            timeout  <= '0;
            sfx_busy <= 1'b1;
          end else if (bgm_ok) begin
            state      <= ST_BGM;
            active_src <= 3'd1;
          end
        end

        ST_BGM: begin
          if (req_any) begin
            state    <= ST_SWITCH;
            tgt_none <= 1'b0;
            tgt_idx  <= req_idx;
            timeout  <= '0;
            sfx_busy <= 1'b1;
          end else if (!bgm_ok) begin
            state    <= ST_SWITCH;
            tgt_none <= 1'b1;
            timeout  <= '0;
          end
        end

        ST_SWITCH: begin
          if (!raw_level || timeout == TO_W'(SW_TIMEOUT - 1)) begin
            if (next_none) begin
              state      <= ST_IDLE;
              active_src <= 3'd0;
              sfx_busy   <= 1'b0;
            end else begin
              state      <= ST_SFX;
              sel        <= next_idx;
              hold       <= HOLD_W'(SFX_HOLD - 1);
              active_src <= 3'd2 + 3'(next_idx);
              sfx_busy   <= 1'b1;
            end
          end else begin
            timeout  <= timeout + 1'b1;
            tgt_none <= next_none;
            tgt_idx  <= next_idx;
            sfx_busy <= !next_none;
          end
        end

        ST_SFX: begin
          if (req_any && req_idx < sel) begin
            // A higher-priority effect preempts the current one.
            state    <= ST_SWITCH;
            tgt_none <= 1'b0;
            tgt_idx  <= req_idx;
            timeout  <= '0;
          end else if (req_any && req_idx == sel) begin
            // A retrigger of the same effect reloads the hold counter.
            hold <= HOLD_W'(SFX_HOLD - 1);
          end else if (hold == '0) begin
            state    <= ST_SWITCH;
            tgt_none <= 1'b1;
            timeout  <= '0;
            sfx_busy <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
